// File: rtl/bram_loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bram_loader_pkg : BRAM geometry and loader state encoding.  Rev 1.0      |
// +--------------------------------------------------------------------------+
package bram_loader_pkg;

  localparam int DATA_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int ADDR_W         = 7;
  localparam int DEPTH          = 72;
  localparam int BYTES_PER_WORD = DATA_W / BYTE_W;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : bram_loader_pkg
`default_nettype wire

// File: rtl/bram_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bram_loader_if : byte-stream input and BRAM write port.  Rev 1.0         |
// +--------------------------------------------------------------------------+
interface bram_loader_if;
  import bram_loader_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_wr_addr;
  logic [DATA_W-1:0] bram_data_in;

  // Environment side: byte source and BRAM sink.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  bram_we,
    input  bram_wr_addr,
    input  bram_data_in
  );

  // Loader side.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output bram_we,
    output bram_wr_addr,
    output bram_data_in
  );

endinterface : bram_loader_if
`default_nettype wire

// File: rtl/bram_loader_byte_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bram_loader_byte_packer : little-endian 4-byte to word packer. Rev 1.0   |
// +--------------------------------------------------------------------------+
module bram_loader_byte_packer
  import bram_loader_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              accept_i,
  input  wire logic              clear_i,
  input  wire logic [BYTE_W-1:0] byte_i,
  output logic                   word_valid_o,
  output logic      [DATA_W-1:0] word_o
);

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] pack_q, pack_d;

  always_comb begin
    cnt_d  = cnt_q;
    pack_d = pack_q;
    if (clear_i) begin
      cnt_d  = '0;
      pack_d = '0;
    end else if (accept_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        if (cnt_q == CNT_W'(k)) begin
          pack_d[k*BYTE_W +: BYTE_W] = byte_i;
        end
      end
    end
  end

  // The completed word is presented in the same cycle as its last byte so the
  // loader can register it straight into the BRAM write port.
  assign word_o       = pack_d;
  assign word_valid_o = accept_i & ~clear_i & (cnt_q == LAST_BYTE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pack_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pack_q <= pack_d;
    end
  end

endmodule : bram_loader_byte_packer
`default_nettype wire

// File: rtl/bram_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bram_loader : byte stream to 72x32 BRAM fill stage.  Rev 1.0             |
// +--------------------------------------------------------------------------+
module bram_loader
  import bram_loader_pkg::*;
(
  input  wire logic     clk,
  input  wire logic     rst_n,
  input  wire logic     start_i,
  input  wire logic     abort_i,
  output logic          busy_o,
  output logic          done_o,
  bram_loader_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] word_cnt_q;
  logic              in_ready_q;
  logic              bram_we_q;
  logic [ADDR_W-1:0] bram_wr_addr_q;
  logic [DATA_W-1:0] bram_data_q;
  logic              busy_q;
  logic              done_q;

  logic              byte_accept;
  logic              pack_clear;
  logic              word_valid;
  logic [DATA_W-1:0] word;

  assign byte_accept = bus.in_valid & in_ready_q;
  // Packer restarts on a fresh load and drops the partial word on abort.
  assign pack_clear  = ((state_q == ST_IDLE) & start_i & ~abort_i) |
                       ((state_q == ST_LOAD) & abort_i);

  bram_loader_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .accept_i     (byte_accept),
    .clear_i      (pack_clear),
    .byte_i       (bus.in_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      word_cnt_q     <= '0;
      in_ready_q     <= 1'b0;
      bram_we_q      <= 1'b0;
      bram_wr_addr_q <= '0;
      bram_data_q    <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      bram_we_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i && !abort_i) begin
            state_q    <= ST_LOAD;
            word_cnt_q <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (abort_i) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
          end else if (word_valid) begin
            bram_we_q      <= 1'b1;
            bram_wr_addr_q <= word_cnt_q;
            bram_data_q    <= word;
            if (word_cnt_q == LAST_ADDR) begin
              state_q    <= ST_DONE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              word_cnt_q <= word_cnt_q + ADDR_W'(1);
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.bram_we      = bram_we_q;
  assign bus.bram_wr_addr = bram_wr_addr_q;
  assign bus.bram_data_in = bram_data_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

endmodule : bram_loader
`default_nettype wire

// File: tb/tb_bram_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bram_loader : directed self-checking bench for bram_loader.  Rev 1.0  |
// +--------------------------------------------------------------------------+
module tb_bram_loader;

  logic clk;
  logic rst_n;
  logic start_i;
  logic abort_i;
  logic busy_o;
  logic done_o;

  bram_loader_if bus ();

  bram_loader dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .abort_i (abort_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int          cyc = 0;
  int          start_cyc;
  logic [6:0]  wa[$];
  logic [31:0] wd[$];
  int          done_cnt;
  int          done_cyc;
  logic [6:0]  done_addr;
  logic        done_we;
  logic        done_rdy;
  logic        done_busy;

  always @(posedge clk) cyc++;

  // Observe writes and the done pulse mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.bram_we) begin
        wa.push_back(bus.bram_wr_addr);
        wd.push_back(bus.bram_data_in);
      end
      if (done_o) begin
        done_cnt++;
        done_cyc  = cyc;
        done_addr = bus.bram_wr_addr;
        done_we   = bus.bram_we;
        done_rdy  = bus.in_ready;
        done_busy = busy_o;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    done_cnt  = 0;
    done_cyc  = 0;
    done_addr = '0;
    done_we   = 1'b0;
    done_rdy  = 1'b0;
    done_busy = 1'b0;
  endtask

  task automatic pulse_start();
    start_i   = 1'b1;
    start_cyc = cyc;
    tick();
    start_i   = 1'b0;
  endtask

  // Offer n bytes base, base+1, ...; gap_pct percent of cycles leave in_valid low.
  task automatic feed(input int n, input int base, input int gap_pct);
    int   sent  = 0;
    int   guard = 0;
    logic acc;
    while (sent < n && guard < 5000) begin
      bus.in_data  = 8'(base + sent);
      bus.in_valid = ($urandom_range(99) >= gap_pct);
      acc = bus.in_valid & bus.in_ready;
      tick();
      if (acc) sent++;
      guard++;
    end
    bus.in_valid = 1'b0;
    if (guard >= 5000) check("feed_timeout", 32'(sent), 32'(n));
  endtask

  task automatic check_full_load(input string tag);
    int errs = 0;
    check({tag, "_nwr"}, 32'(wa.size()), 32'd72);
    for (int w = 0; w < wa.size() && w < 72; w++) begin
      if (wa[w] !== 7'(w) ||
          wd[w] !== {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}) errs++;
    end
    check({tag, "_pair_errs"}, 32'(errs), 32'd0);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_addr"}, {25'd0, done_addr}, 32'd71);
    check({tag, "_done_we"}, {31'd0, done_we}, 32'd1);
  endtask

  initial begin
    rst_n        = 1'b0;
    start_i      = 1'b0;
    abort_i      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    clear_log();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Idle: bytes offered without start are never consumed.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    for (int i = 0; i < 10; i++) begin
      check("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
    end
    bus.in_valid = 1'b0;
    check("idle_nwr", 32'(wa.size()), 32'd0);
    check("idle_outputs", {bus.bram_we, bus.bram_wr_addr, bus.bram_data_in[23:0], busy_o, done_o},
          32'd0);
    check("idle_data", bus.bram_data_in, 32'd0);

    // Full load, no stalls.
    clear_log();
    pulse_start();
    check("start_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("start_busy", {31'd0, busy_o}, 32'd1);
    feed(288, 0, 0);
    repeat (3) tick();
    check_full_load("nostall");
    check("nostall_w0_addr", {25'd0, wa[0]}, 32'd0);
    check("nostall_w0_data", wd[0], 32'h0302_0100);
    check("nostall_w71_addr", {25'd0, wa[71]}, 32'd71);
    check("nostall_w71_data", wd[71], 32'h1F1E_1D1C);
    check("nostall_done_lat", 32'(done_cyc - start_cyc), 32'd289);
    check("nostall_done_rdy", {31'd0, done_rdy}, 32'd0);
    check("nostall_done_busy", {31'd0, done_busy}, 32'd0);
    check("nostall_idle_busy", {31'd0, busy_o}, 32'd0);
    check("nostall_hold_addr", {25'd0, bus.bram_wr_addr}, 32'd71);

    // Same load with ~30% idle input cycles.
    clear_log();
    pulse_start();
    feed(288, 0, 30);
    repeat (3) tick();
    check_full_load("gaps");

    // Abort with word 1 half filled.
    clear_log();
    pulse_start();
    feed(6, 'h40, 0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd0);
    repeat (3) tick();
    check("abort_nwr", 32'(wa.size()), 32'd1);
    check("abort_w0", wd[0], 32'h4342_4140);
    clear_log();
    pulse_start();
    feed(4, 'h80, 0);
    tick();
    check("restart_nwr", 32'(wa.size()), 32'd1);
    check("restart_addr", {25'd0, wa[0]}, 32'd0);
    check("restart_data", wd[0], 32'h8382_8180);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;

    // start while busy must not reset either counter.
    clear_log();
    pulse_start();
    feed(2, 'h10, 0);
    pulse_start();
    check("busy_start_busy", {31'd0, busy_o}, 32'd1);
    feed(2, 'h12, 0);
    feed(4, 'h14, 0);
    tick();
    check("busy_start_nwr", 32'(wa.size()), 32'd2);
    check("busy_start_w0", wd[0], 32'h1312_1110);
    check("busy_start_a1", {25'd0, wa[1]}, 32'd1);
    check("busy_start_w1", wd[1], 32'h1716_1514);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;

    // start and abort together in IDLE: stays idle.
    clear_log();
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    check("both_busy", {31'd0, busy_o}, 32'd0);
    check("both_in_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b0;
    check("both_nwr", 32'(wa.size()), 32'd0);

    // Reset mid-load after 40 bytes.
    clear_log();
    pulse_start();
    feed(40, 'h20, 0);
    check("prereset_nwr", 32'(wa.size()), 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_we", {31'd0, bus.bram_we}, 32'd0);
    check("rst_addr", {25'd0, bus.bram_wr_addr}, 32'd0);
    check("rst_data", bus.bram_data_in, 32'd0);
    check("rst_busy_done", {30'd0, busy_o, done_o}, 32'd0);
    tick();
    rst_n = 1'b1;
    clear_log();
    bus.in_valid = 1'b1;
    repeat (6) tick();
    bus.in_valid = 1'b0;
    check("postrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("postrst_nwr", 32'(wa.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_bram_loader
`default_nettype wire
